// File: rtl/pc_next_pkg.sv
// Shared constants for the PC-next unit: default geometry, reset/trap
// vectors, and the redirect source indices (lower index = higher priority).
// Optional build macro used by pc_next_unit: MISALIGN_TRAP_EN.
package pc_next_pkg;

  localparam int          DEF_WIDTH    = 32;
  localparam int          DEF_NUM_SRC  = 4;
  localparam int          DEF_INC      = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0080;

  // Redirect source slots, index 0 wins arbitration
  localparam int SRC_EXC    = 0;
  localparam int SRC_JR     = 1;
  localparam int SRC_JUMP   = 2;
  localparam int SRC_BRANCH = 3;

endpackage

// File: rtl/pc_next_unit_prio_enc.sv
// Lowest-index-first priority encoder: one-hot grant, binary index and any-flag.
// Purely combinational, zero latency; no backpressure.
module prio_enc_onehot #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  // Scan from the top down so the lowest asserted index is the last to write
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC register with fixed-priority redirect select and a 1-entry redirect buffer held across stalls.
// Latency: redirect on cycle n appears on PC_Out at n+1 (or the cycle after Stall falls if buffered).
// Backpressure: Stall freezes PC_Out/Src_Taken; one redirect is buffered, lower-priority ones dropped.
// Build option: define MISALIGN_TRAP_EN to divert misaligned redirect targets to TRAP_VEC.
module pc_next_unit
  import pc_next_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               NUM_SRC  = DEF_NUM_SRC,
  parameter int               INC      = DEF_INC,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(DEF_TRAP_VEC)
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Stall,
  input  logic [NUM_SRC-1:0]       Redirect_Valid,
  input  logic [NUM_SRC*WIDTH-1:0] Redirect_Target,
  output logic [WIDTH-1:0]         PC_Out,
  output logic [WIDTH-1:0]         PC_Plus_Inc,
  output logic [NUM_SRC-1:0]       Src_Taken,
  output logic                     Pending,
  output logic                     Misalign
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] new_oh;
  logic [IW-1:0]      new_idx;
  logic               new_any;
  logic [WIDTH-1:0]   new_tgt;

  logic [IW-1:0]      pend_idx;
  logic [WIDTH-1:0]   pend_tgt;

  logic               take_new;
  logic               redir;
  logic [IW-1:0]      sel_idx;
  logic [WIDTH-1:0]   sel_tgt;
  logic [NUM_SRC-1:0] sel_oh;

  prio_enc_onehot #(.N(NUM_SRC), .IW(IW)) u_enc (
    .req    (Redirect_Valid),
    .onehot (new_oh),
    .index  (new_idx),
    .any    (new_any)
  );

  assign new_tgt     = Redirect_Target[new_idx*WIDTH +: WIDTH];
  assign PC_Plus_Inc = PC_Out + WIDTH'(INC);

  // A new request beats the buffered one unless the buffered one is strictly higher priority;
  // the same test decides replacement of the buffer while stalled
  assign take_new = new_any && (!Pending || (new_idx <= pend_idx));
  assign redir    = new_any || Pending;

  // Pick the winning redirect and form its one-hot source tag
  always_comb begin
    sel_idx = take_new ? new_idx : pend_idx;
    sel_tgt = take_new ? new_tgt : pend_tgt;
    sel_oh  = '0;
    if (take_new) begin
      sel_oh = new_oh;
    end else begin
      sel_oh[sel_idx] = 1'b1;
    end
  end

  // PC, source tag and redirect buffer update
  always_ff @(posedge Clk) begin
    if (Rst) begin
      PC_Out    <= RESET_PC;
      Src_Taken <= '0;
      Pending   <= 1'b0;
      pend_idx  <= '0;
      pend_tgt  <= '0;
    end else if (Stall) begin
      if (take_new) begin
        Pending  <= 1'b1;
        pend_idx <= new_idx;
        pend_tgt <= new_tgt;
      end
    end else begin
      // Buffer is either consumed here or superseded by a better new request
      Pending <= 1'b0;
      if (redir) begin
        Src_Taken <= sel_oh;
`ifdef MISALIGN_TRAP_EN
        PC_Out <= (sel_tgt[1:0] != 2'b00) ? TRAP_VEC : sel_tgt;
`else
        PC_Out <= sel_tgt;
`endif
      end else begin
        Src_Taken <= '0;
        PC_Out    <= PC_Plus_Inc;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle flag when a selected redirect target was diverted to the trap vector
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Misalign <= 1'b0;
    end else begin
      Misalign <= !Stall && redir && (sel_tgt[1:0] != 2'b00);
    end
  end
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
  assign Misalign        = 1'b0;
`endif

endmodule
